// File: rtl/adc_block_avg_if.sv
// adc_block_avg_if: sample input and window-statistics output bundle for adc_block_avg.
interface adc_block_avg_if #(parameter int DW = 12, parameter int CW = 16);
  logic          en_i;
  logic          eoc_i;
  logic [DW-1:0] din_i;
  logic [DW-1:0] avg_o;
  logic [DW-1:0] min_o;
  logic [DW-1:0] max_o;
  logic          valid_o;
  logic [CW-1:0] win_cnt_o;
  logic          sat_o;
  modport master (output en_i, eoc_i, din_i,
                  input  avg_o, min_o, max_o, valid_o, win_cnt_o, sat_o);
  modport slave  (input  en_i, eoc_i, din_i,
                  output avg_o, min_o, max_o, valid_o, win_cnt_o, sat_o);
endinterface

// File: rtl/adc_block_avg.sv
// adc_block_avg: mean/min/max over windows of 2^LOG2N ADC samples; ADC_AVG_SAT_EN adds a rail-hit flag.
module adc_block_avg #(
  parameter int DW    = 12,
  parameter int LOG2N = 4,
  parameter int CW    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  adc_block_avg_if.slave   bus
);
  localparam int AW = DW + LOG2N;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t st_q, st_d;
  logic             eoc_q;
  logic [AW-1:0]    sum_q, sum_d, tot;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    lo_q, lo_d, hi_q, hi_d, lo_n, hi_n;
  logic [DW-1:0]    avg_q, avg_d, min_q, min_d, max_q, max_d;
  logic [CW-1:0]    win_q, win_d;
  logic             ev, keep, take, last;
  assign ev   = bus.eoc_i & ~eoc_q;
  assign keep = bus.en_i & (st_q != IDLE);
  assign take = ev & keep;
  // the N-th sample is the one taken while the counter is all ones
  assign last = take & (&cnt_q);
  assign tot  = sum_q + AW'(bus.din_i);
  assign lo_n = (cnt_q == '0 || bus.din_i < lo_q) ? bus.din_i : lo_q;
  assign hi_n = (cnt_q == '0 || bus.din_i > hi_q) ? bus.din_i : hi_q;
  always_comb begin
    st_d  = !bus.en_i ? IDLE : last ? DONE : ACC;
    sum_d = (!keep || last) ? '0 : take ? tot : sum_q;
    cnt_d = !keep ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    lo_d  = take ? lo_n : lo_q;
    hi_d  = take ? hi_n : hi_q;
    avg_d = last ? tot[AW-1:LOG2N] : avg_q;
    min_d = last ? lo_n : min_q;
    max_d = last ? hi_n : max_q;
    win_d = last ? win_q + 1'b1 : win_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st_q  <= IDLE;
      eoc_q <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      avg_q <= '0;
      min_q <= '0;
      max_q <= '0;
      win_q <= '0;
    end else begin
      st_q  <= st_d;
      eoc_q <= bus.eoc_i;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      avg_q <= avg_d;
      min_q <= min_d;
      max_q <= max_d;
      win_q <= win_d;
    end
  end
  assign bus.avg_o     = avg_q;
  assign bus.min_o     = min_q;
  assign bus.max_o     = max_q;
  assign bus.win_cnt_o = win_q;
  assign bus.valid_o   = (st_q == DONE);
`ifdef ADC_AVG_SAT_EN
  logic flag_q, flag_d, flag_n, sat_q, sat_d;
  assign flag_n = ((cnt_q != '0) && flag_q) || (bus.din_i == '0) || (&bus.din_i);
  always_comb begin
    flag_d = (!keep || last) ? 1'b0 : take ? flag_n : flag_q;
    sat_d  = last ? flag_n : sat_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flag_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      sat_q  <= sat_d;
    end
  end
  assign bus.sat_o = sat_q;
`else
  assign bus.sat_o = 1'b0;
`endif
endmodule

// File: doc/adc_block_avg.md
Name: adc_block_avg

Overview:
- Downstream consumer of the SPI ADC capture stage.
- Takes each 12-bit conversion result, qualified by the end-of-conversion strobe, and accumulates a window of 2^LOG2N samples.
- Per completed window, publishes the mean, minimum and maximum, a one-cycle valid pulse and a running window count.
- Outputs feed the display and logging stages of the bolometer readout.

Parameters:
DW, 12, sample width; matches ADC result width.
LOG2N, 4, log2 of window length; window N = 2^LOG2N samples (16). Legal range 1..8.
CW, 16, width of the completed-window counter.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  asynchronous, active-low reset.
en_i  in  1  averaging enable; low discards any partial window.
eoc_i  in  1  end-of-conversion from the SPI ADC stage; pulse or level, rising edge used.
din_i  in  DW  conversion result; stable when eoc_i rises.
avg_o  out  DW  window mean.
min_o  out  DW  window minimum.
max_o  out  DW  window maximum.
valid_o  out  1  one-cycle pulse when avg_o/min_o/max_o update.
win_cnt_o  out  CW  number of completed windows.
sat_o  out  1  saturation flag (see Optional Feature).

Behaviour:
- Reset (rst_i=0, async):
  - All outputs 0; FSM to IDLE.
  - Accumulator, sample counter, edge register and min/max trackers cleared.
  - Reset mid-window discards the window with no valid_o.
- Sample event:
  - eoc_q registers eoc_i every cycle; ev = eoc_i & ~eoc_q.
  - din_i is sampled in the ev cycle.
  - A level held high for many cycles is one event.
- Accumulator:
  - Width DW+LOG2N, unsigned, cannot overflow.
  - Sample counter is LOG2N bits.
- FSM states IDLE, ACC, DONE:
  - IDLE: counters/accumulator held at 0; ev ignored; en_i=1 -> ACC on next edge.
  - ACC, ev with cnt<N-1: sum+=din_i; cnt+=1. First sample of a window (cnt=0) loads min/max trackers directly; later samples use compare-update.
  - ACC, ev with cnt=N-1, on that same edge:
    - avg_o <= (sum+din_i)>>LOG2N, truncating (floor).
    - min_o/max_o <= final trackers including din_i.
    - win_cnt_o += 1, wrapping 2^CW-1 -> 0.
    - sum, cnt cleared; -> DONE.
  - DONE: valid_o=1 for exactly this one cycle. Next state is ACC if en_i=1, else IDLE.
  - ev arriving in the DONE cycle is accepted as sample 0 of the next window; no sample lost.
- Latency: valid_o is high in the cycle after the edge that captured the N-th sample; outputs already updated in that cycle.
- en_i=0 in ACC:
  - -> IDLE next edge; partial window discarded; no valid_o.
  - avg_o/min_o/max_o/win_cnt_o hold their last values.
  - An ev coinciding with en_i=0 is dropped.
- Hold rule: outputs change only on the window-completion edge or reset.

Optional Feature:
- Macro ADC_AVG_SAT_EN.
- Defined:
  - Per-window sticky flag sets when any accepted sample equals 0 or 2^DW-1.
  - sat_o loads the flag on the window-completion edge, alongside avg_o.
  - Flag clears with the accumulator and on IDLE.
- Undefined: sat_o tied 0; no flag logic.

Test Plan:
- Reset release, en_i=1, 16 events din_i=12'h800 -> avg_o=12'h800, min_o=max_o=12'h800, valid_o high exactly 1 cycle, win_cnt_o=1.
- 16 events din_i=0..15 ascending -> avg_o=7 (120>>4), min_o=0, max_o=15; second window of 16x12'hFFF -> avg_o=12'hFFF, win_cnt_o=2.
- eoc_i held high 5 cycles per sample, 16 samples of 12'h010 -> exactly 16 events counted, avg_o=12'h010, single valid_o.
- 7 events of 12'h100, then en_i=0 for 3 cycles, then en_i=1 and 16 events of 12'h200 -> no valid_o during partial window; final avg_o=12'h200, min_o=12'h200.
- rst_i low after 10 samples -> all outputs 0 asynchronously; after release, 16 events of 12'h0AA -> avg_o=12'h0AA, win_cnt_o=1.
- With ADC_AVG_SAT_EN: window of 15x12'h400 plus one 12'hFFF -> sat_o=1, avg_o=12'h4BF; next window all 12'h400 -> sat_o=0. Without macro -> sat_o=0 throughout.
